// File: rtl/data_path.sv
// data_path: single-cycle RV32I-subset core. Fetch, decode, execute, memory
// and write-back all complete within one clock; state is the PC, the
// register file and the data memory.

// Instruction ROM, word-indexed, combinational read, preloaded hierarchically.
module imem (
  input  logic [5:0]  addr,
  output logic [31:0] rdata
);
  logic [31:0] mem [0:63];

  initial begin
    for (int unsigned i = 0; i < 64; i++) mem[i] = '0;
  end

  assign rdata = mem[addr];
endmodule

// 32 x 32 register file: two combinational read ports, one write port.
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] reg_file [0:31];

  // Clear everything on reset; writes to x0 are dropped so it stays zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) reg_file[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      reg_file[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : reg_file[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : reg_file[ra2];
endmodule

// Data RAM: word access, combinational read, write on the rising edge.
// Not reset; zeroed once at start of simulation.
module dmem (
  input  logic        clk,
  input  logic        we,
  input  logic [5:0]  addr,
  input  logic [31:0] wd,
  output logic [31:0] rdata
);
  logic [31:0] ram [0:63];

  initial begin
    for (int unsigned i = 0; i < 64; i++) ram[i] = '0;
  end

  // Store port
  always_ff @(posedge clk) begin
    if (we) ram[addr] <= wd;
  end

  assign rdata = ram[addr];
endmodule

module data_path (
  input logic clk,
  input logic rst
);
  typedef enum logic [6:0] {
    OPC_RTYPE  = 7'b0110011,
    OPC_ITYPE  = 7'b0010011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_LUI    = 7'b0110111
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_e;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} wb_sel_e;

  logic [31:0] pc_current_r;
  logic [31:0] pc_next, pc_plus4, pc_target;
  logic [31:0] instr, imm, rs1_val, rs2_val, alu_b, alu_y, mem_rdata, wb_data;
  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        reg_we, mem_we, alu_src_imm, is_branch, is_jal, is_jalr, br_taken;
  alu_op_e     alu_op, alu_func;
  wb_sel_e     wb_sel;

  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign funct7_5 = instr[30];

  imem im0 (
    .addr  (pc_current_r[7:2]),
    .rdata (instr)
  );

  regfile rf0 (
    .clk (clk),
    .rst (rst),
    .we  (reg_we),
    .ra1 (rs1),
    .ra2 (rs2),
    .wa  (rd),
    .wd  (wb_data),
    .rd1 (rs1_val),
    .rd2 (rs2_val)
  );

  dmem dm0 (
    .clk   (clk),
    .we    (mem_we & ~rst),
    .addr  (alu_y[7:2]),
    .wd    (rs2_val),
    .rdata (mem_rdata)
  );

  // Program counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_current_r <= '0;
    else     pc_current_r <= pc_next;
  end

  // Immediate generator: sign-extended I/S/B/J formats, U keeps upper 20 bits
  always_comb begin
    imm = '0;
    case (opcode)
      OPC_ITYPE, OPC_LOAD, OPC_JALR:
        imm = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_JAL:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      OPC_LUI:
        imm = {instr[31:12], 12'h000};
      default: imm = '0;
    endcase
  end

  // ALU function from funct3; bit 30 selects SUB only for R-type, SRA/SRAI for both
  always_comb begin
    alu_func = ALU_ADD;
    case (funct3)
      3'b000: alu_func = (opcode == OPC_RTYPE && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001: alu_func = ALU_SLL;
      3'b010: alu_func = ALU_SLT;
      3'b011: alu_func = ALU_SLTU;
      3'b100: alu_func = ALU_XOR;
      3'b101: alu_func = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110: alu_func = ALU_OR;
      default: alu_func = ALU_AND;
    endcase
  end

  // Main decoder; anything unrecognised falls through as a NOP
  always_comb begin
    reg_we      = 1'b0;
    mem_we      = 1'b0;
    alu_src_imm = 1'b0;
    is_branch   = 1'b0;
    is_jal      = 1'b0;
    is_jalr     = 1'b0;
    alu_op      = ALU_ADD;
    wb_sel      = WB_ALU;
    case (opcode)
      OPC_RTYPE: begin
        reg_we = 1'b1;
        alu_op = alu_func;
      end
      OPC_ITYPE: begin
        reg_we      = 1'b1;
        alu_src_imm = 1'b1;
        alu_op      = alu_func;
      end
      OPC_LOAD: begin
        if (funct3 == 3'b010) begin
          reg_we      = 1'b1;
          alu_src_imm = 1'b1;
          wb_sel      = WB_MEM;
        end
      end
      OPC_STORE: begin
        if (funct3 == 3'b010) begin
          mem_we      = 1'b1;
          alu_src_imm = 1'b1;
        end
      end
      OPC_BRANCH: is_branch = 1'b1;
      OPC_JAL: begin
        reg_we = 1'b1;
        is_jal = 1'b1;
        wb_sel = WB_PC4;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          reg_we      = 1'b1;
          is_jalr     = 1'b1;
          alu_src_imm = 1'b1;
          wb_sel      = WB_PC4;
        end
      end
      OPC_LUI: begin
        reg_we = 1'b1;
        wb_sel = WB_IMM;
      end
      default: ;
    endcase
  end

  assign alu_b = alu_src_imm ? imm : rs2_val;

  // ALU; shift amount is the low five bits of the second operand
  always_comb begin
    alu_y = '0;
    case (alu_op)
      ALU_ADD:  alu_y = rs1_val + alu_b;
      ALU_SUB:  alu_y = rs1_val - alu_b;
      ALU_AND:  alu_y = rs1_val & alu_b;
      ALU_OR:   alu_y = rs1_val | alu_b;
      ALU_XOR:  alu_y = rs1_val ^ alu_b;
      ALU_SLT:  alu_y = {31'd0, $signed(rs1_val) < $signed(alu_b)};
      ALU_SLTU: alu_y = {31'd0, rs1_val < alu_b};
      ALU_SLL:  alu_y = rs1_val << alu_b[4:0];
      ALU_SRL:  alu_y = rs1_val >> alu_b[4:0];
      ALU_SRA:  alu_y = $unsigned($signed(rs1_val) >>> alu_b[4:0]);
      default:  alu_y = '0;
    endcase
  end

  // Branch condition; unsupported funct3 encodings never branch
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      default: br_taken = 1'b0;
    endcase
  end

  assign pc_plus4  = pc_current_r + 32'd4;
  assign pc_target = pc_current_r + imm;

  // Next-PC select: PC-relative for JAL/taken branch, rs1+imm with bit 0 cleared for JALR
  always_comb begin
    pc_next = pc_plus4;
    if (is_jal || (is_branch && br_taken)) pc_next = pc_target;
    else if (is_jalr)                      pc_next = {alu_y[31:1], 1'b0};
  end

  // Write-back source select
  always_comb begin
    wb_data = alu_y;
    case (wb_sel)
      WB_MEM:  wb_data = mem_rdata;
      WB_PC4:  wb_data = pc_plus4;
      WB_IMM:  wb_data = imm;
      default: wb_data = alu_y;
    endcase
  end
endmodule

// File: tb/tb_data_path.sv
// tb_data_path: runs directed and random programs on data_path and compares
// PC, register file and data memory against an instruction-level model.
module tb_data_path;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  data_path dut (
    .clk (clk),
    .rst (rst)
  );

  typedef enum {
    I_ADD, I_SUB, I_AND, I_OR, I_XOR, I_SLT, I_SLTU, I_SLL, I_SRL, I_SRA,
    I_ADDI, I_ANDI, I_ORI, I_XORI, I_SLTI, I_SLLI, I_SRLI, I_SRAI,
    I_LW, I_SW, I_BEQ, I_BNE, I_BLT, I_BGE, I_JAL, I_JALR, I_LUI, I_NOP
  } op_e;

  typedef struct {
    op_e         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } ins_t;

  int n_checks = 0;
  int n_fail   = 0;

  ins_t        prog  [0:63];
  ins_t        cur   [$];
  logic [31:0] m_reg [0:31];
  logic [31:0] m_mem [0:63];
  logic [31:0] m_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ins_t mk(op_e op, int rd, int rs1, int rs2, int imm);
    ins_t t;
    t.op  = op;
    t.rd  = 5'(rd);
    t.rs1 = 5'(rs1);
    t.rs2 = 5'(rs2);
    t.imm = 32'(imm);
    return t;
  endfunction

  // Instruction word assembly from the RV32I formats
  function automatic logic [31:0] enc(ins_t t);
    logic [31:0] m;
    logic [6:0]  f7;
    logic [2:0]  f3;
    m  = t.imm;
    f7 = 7'h00;
    f3 = 3'd0;
    case (t.op)
      I_ADD, I_SUB, I_AND, I_OR, I_XOR, I_SLT, I_SLTU, I_SLL, I_SRL, I_SRA: begin
        case (t.op)
          I_SUB:  begin f3 = 3'd0; f7 = 7'h20; end
          I_SLL:  f3 = 3'd1;
          I_SLT:  f3 = 3'd2;
          I_SLTU: f3 = 3'd3;
          I_XOR:  f3 = 3'd4;
          I_SRL:  f3 = 3'd5;
          I_SRA:  begin f3 = 3'd5; f7 = 7'h20; end
          I_OR:   f3 = 3'd6;
          I_AND:  f3 = 3'd7;
          default: f3 = 3'd0;
        endcase
        return {f7, t.rs2, t.rs1, f3, t.rd, 7'b0110011};
      end
      I_ADDI: return {m[11:0], t.rs1, 3'd0, t.rd, 7'b0010011};
      I_SLTI: return {m[11:0], t.rs1, 3'd2, t.rd, 7'b0010011};
      I_XORI: return {m[11:0], t.rs1, 3'd4, t.rd, 7'b0010011};
      I_ORI:  return {m[11:0], t.rs1, 3'd6, t.rd, 7'b0010011};
      I_ANDI: return {m[11:0], t.rs1, 3'd7, t.rd, 7'b0010011};
      I_SLLI: return {7'h00, m[4:0], t.rs1, 3'd1, t.rd, 7'b0010011};
      I_SRLI: return {7'h00, m[4:0], t.rs1, 3'd5, t.rd, 7'b0010011};
      I_SRAI: return {7'h20, m[4:0], t.rs1, 3'd5, t.rd, 7'b0010011};
      I_LW:   return {m[11:0], t.rs1, 3'd2, t.rd, 7'b0000011};
      I_SW:   return {m[11:5], t.rs2, t.rs1, 3'd2, m[4:0], 7'b0100011};
      I_BEQ:  return {m[12], m[10:5], t.rs2, t.rs1, 3'd0, m[4:1], m[11], 7'b1100011};
      I_BNE:  return {m[12], m[10:5], t.rs2, t.rs1, 3'd1, m[4:1], m[11], 7'b1100011};
      I_BLT:  return {m[12], m[10:5], t.rs2, t.rs1, 3'd4, m[4:1], m[11], 7'b1100011};
      I_BGE:  return {m[12], m[10:5], t.rs2, t.rs1, 3'd5, m[4:1], m[11], 7'b1100011};
      I_JAL:  return {m[20], m[10:1], m[11], m[19:12], t.rd, 7'b1101111};
      I_JALR: return {m[11:0], t.rs1, 3'd0, t.rd, 7'b1100111};
      I_LUI:  return {m[31:12], t.rd, 7'b0110111};
      default: return {m[24:0], 7'b0001111};
    endcase
  endfunction

  // Executes one instruction on the architectural state
  task automatic model_step(output logic [4:0] wr_rd, output int sw_idx);
    ins_t        t;
    logic [31:0] a, b, res, npc, addr;
    bit          we;
    t      = prog[int'((m_pc / 4) % 64)];
    a      = m_reg[t.rs1];
    b      = m_reg[t.rs2];
    npc    = m_pc + 4;
    res    = 0;
    we     = 1;
    sw_idx = -1;
    addr   = a + t.imm;
    case (t.op)
      I_ADD:  res = a + b;
      I_SUB:  res = a - b;
      I_AND:  res = a & b;
      I_OR:   res = a | b;
      I_XOR:  res = a ^ b;
      I_SLT:  res = ($signed(a) < $signed(b)) ? 1 : 0;
      I_SLTU: res = (a < b) ? 1 : 0;
      I_SLL:  res = a << (b % 32);
      I_SRL:  res = a >> (b % 32);
      I_SRA:  res = $unsigned($signed(a) >>> (b % 32));
      I_ADDI: res = a + t.imm;
      I_ANDI: res = a & t.imm;
      I_ORI:  res = a | t.imm;
      I_XORI: res = a ^ t.imm;
      I_SLTI: res = ($signed(a) < $signed(t.imm)) ? 1 : 0;
      I_SLLI: res = a << (t.imm % 32);
      I_SRLI: res = a >> (t.imm % 32);
      I_SRAI: res = $unsigned($signed(a) >>> (t.imm % 32));
      I_LW:   res = m_mem[int'((addr / 4) % 64)];
      I_SW: begin
        we     = 0;
        sw_idx = int'((addr / 4) % 64);
        m_mem[sw_idx] = b;
      end
      I_BEQ: begin we = 0; if (a == b) npc = m_pc + t.imm; end
      I_BNE: begin we = 0; if (a != b) npc = m_pc + t.imm; end
      I_BLT: begin we = 0; if ($signed(a) <  $signed(b)) npc = m_pc + t.imm; end
      I_BGE: begin we = 0; if ($signed(a) >= $signed(b)) npc = m_pc + t.imm; end
      I_JAL:  begin res = m_pc + 4; npc = m_pc + t.imm; end
      I_JALR: begin res = m_pc + 4; npc = addr & ~32'd1; end
      I_LUI:  res = t.imm;
      default: we = 0;
    endcase
    if (we && t.rd != 0) m_reg[t.rd] = res;
    wr_rd = we ? t.rd : 5'd0;
    m_pc  = npc;
  endtask

  function automatic ins_t rand_nop();
    return mk(I_NOP, int'($urandom_range(0, 31)), 0, 0, int'($urandom));
  endfunction

  function automatic ins_t rand_ins();
    ins_t        t;
    logic [31:0] r;
    t = mk(op_e'($urandom_range(0, 27)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 0);
    r = $urandom;
    case (t.op)
      I_ADDI, I_ANDI, I_ORI, I_XORI, I_SLTI, I_LW, I_SW:
        t.imm = 32'(int'($urandom_range(0, 4095)) - 2048);
      I_SLLI, I_SRLI, I_SRAI: t.imm = $urandom_range(0, 31);
      I_BEQ, I_BNE, I_BLT, I_BGE, I_JAL:
        t.imm = 32'(int'($urandom_range(0, 12)) * 4 - 24);
      I_JALR: t.imm = 32'(int'($urandom_range(0, 64)) - 32);
      I_LUI:  t.imm = {r[31:12], 12'h000};
      I_NOP:  t.imm = r;
      default: t.imm = 0;
    endcase
    return t;
  endfunction

  // Loads cur[] into the model and the DUT, holds reset 5 cycles, checks reset state
  task automatic start_prog(input string tag);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (i < cur.size()) prog[i] = cur[i];
      else                prog[i] = rand_nop();
      dut.im0.mem[i] = enc(prog[i]);
    end
    repeat (5) @(negedge clk);
    check({tag, "_rst_pc"}, dut.pc_current_r, 32'h0);
    for (int i = 0; i < 32; i++)
      check($sformatf("%s_rst_x%0d", tag, i), dut.rf0.reg_file[i], 32'h0);
    for (int i = 0; i < 64; i++)
      check($sformatf("%s_rst_ram%0d", tag, i), dut.dm0.ram[i], m_mem[i]);
    m_pc = 0;
    for (int i = 0; i < 32; i++) m_reg[i] = 0;
    rst = 1'b0;
  endtask

  task automatic run_cycles(input int n, input string tag);
    logic [4:0] wr;
    int         sw;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      model_step(wr, sw);
      @(negedge clk);
      check({tag, "_pc"}, dut.pc_current_r, m_pc);
      if (wr != 0) check($sformatf("%s_x%0d", tag, wr), dut.rf0.reg_file[wr], m_reg[wr]);
      if (sw >= 0) check($sformatf("%s_ram%0d", tag, sw), dut.dm0.ram[sw], m_mem[sw]);
    end
  endtask

  task automatic final_compare(input string tag);
    for (int i = 0; i < 32; i++)
      check($sformatf("%s_end_x%0d", tag, i), dut.rf0.reg_file[i], m_reg[i]);
    for (int i = 0; i < 64; i++)
      check($sformatf("%s_end_ram%0d", tag, i), dut.dm0.ram[i], m_mem[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) m_mem[i] = 0;
    for (int i = 0; i < 32; i++) m_reg[i] = 0;
    m_pc = 0;
    #1;

    // ALU
    cur = {};
    cur.push_back(mk(I_ADDI, 5, 0, 0, 7));
    cur.push_back(mk(I_ADDI, 6, 0, 0, -3));
    cur.push_back(mk(I_ADD,  7, 5, 6, 0));
    cur.push_back(mk(I_SUB,  8, 5, 6, 0));
    cur.push_back(mk(I_SLT,  9, 6, 5, 0));
    cur.push_back(mk(I_SRAI, 10, 6, 0, 1));
    cur.push_back(mk(I_ADDI, 11, 0, 0, 1));
    cur.push_back(mk(I_SRA,  12, 6, 11, 0));
    cur.push_back(mk(I_SLTU, 13, 6, 5, 0));
    cur.push_back(mk(I_JAL,  0, 0, 0, 0));
    start_prog("alu");
    run_cycles(12, "alu");
    check("alu_x7",  dut.rf0.reg_file[7],  32'd4);
    check("alu_x8",  dut.rf0.reg_file[8],  32'd10);
    check("alu_x9",  dut.rf0.reg_file[9],  32'd1);
    check("alu_x10", dut.rf0.reg_file[10], 32'hFFFF_FFFE);
    check("alu_x12", dut.rf0.reg_file[12], 32'hFFFF_FFFE);
    check("alu_x13", dut.rf0.reg_file[13], 32'd0);
    final_compare("alu");

    // Memory
    cur = {};
    cur.push_back(mk(I_ADDI, 5, 0, 0, 'h55));
    cur.push_back(mk(I_SW,   0, 0, 5, 48));
    cur.push_back(mk(I_LW,   6, 0, 0, 48));
    cur.push_back(mk(I_JAL,  0, 0, 0, 0));
    start_prog("mem");
    run_cycles(6, "mem");
    check("mem_ram12", dut.dm0.ram[12], 32'h55);
    check("mem_x6",    dut.rf0.reg_file[6], 32'h55);
    for (int i = 0; i <= 4; i++)
      check($sformatf("mem_ram%0d_zero", i), dut.dm0.ram[i], 32'h0);
    final_compare("mem");

    // x0 discard; a store at address 0 must not fire while reset is held
    cur = {};
    cur.push_back(mk(I_SW,   0, 0, 0, 48));
    cur.push_back(mk(I_ADDI, 5, 0, 0, 9));
    cur.push_back(mk(I_ADDI, 0, 0, 0, 5));
    cur.push_back(mk(I_JAL,  0, 0, 0, 0));
    start_prog("x0");
    run_cycles(6, "x0");
    check("x0_x0", dut.rf0.reg_file[0], 32'h0);
    check("x0_x5", dut.rf0.reg_file[5], 32'd9);
    final_compare("x0");

    // Branches with negative operands
    cur = {};
    cur.push_back(mk(I_ADDI, 1, 0, 0, -5));
    cur.push_back(mk(I_ADDI, 2, 0, 0, 3));
    cur.push_back(mk(I_BEQ,  0, 1, 1, 8));
    cur.push_back(mk(I_ADDI, 10, 0, 0, 1));
    cur.push_back(mk(I_BEQ,  0, 1, 2, 8));
    cur.push_back(mk(I_BNE,  0, 1, 2, 8));
    cur.push_back(mk(I_ADDI, 10, 0, 0, 2));
    cur.push_back(mk(I_BLT,  0, 1, 2, 8));
    cur.push_back(mk(I_ADDI, 10, 0, 0, 3));
    cur.push_back(mk(I_BGE,  0, 1, 2, 8));
    cur.push_back(mk(I_BGE,  0, 2, 1, 8));
    cur.push_back(mk(I_ADDI, 10, 0, 0, 4));
    cur.push_back(mk(I_BLT,  0, 2, 1, 8));
    cur.push_back(mk(I_BGE,  0, 1, 1, 8));
    cur.push_back(mk(I_ADDI, 10, 0, 0, 5));
    cur.push_back(mk(I_JAL,  0, 0, 0, 0));
    start_prog("br");
    run_cycles(16, "br");
    check("br_pc_final", dut.pc_current_r, 32'h3C);
    check("br_x10",      dut.rf0.reg_file[10], 32'h0);
    final_compare("br");

    // Jumps
    cur = {};
    for (int i = 0; i < 4; i++) cur.push_back(mk(I_ADDI, 0, 0, 0, 0));
    cur.push_back(mk(I_JAL,  1, 0, 0, 8));
    cur.push_back(mk(I_JAL,  0, 0, 0, 0));
    cur.push_back(mk(I_JALR, 0, 1, 0, 0));
    start_prog("jmp");
    run_cycles(5, "jmp");
    check("jal_pc", dut.pc_current_r, 32'h18);
    check("jal_x1", dut.rf0.reg_file[1], 32'h14);
    run_cycles(1, "jmp");
    check("jalr_pc", dut.pc_current_r, 32'h14);
    run_cycles(3, "jmp");
    check("loop_pc", dut.pc_current_r, 32'h14);

    // Sum 1..10
    cur = {};
    cur.push_back(mk(I_ADDI, 5, 0, 0, 1));
    cur.push_back(mk(I_ADDI, 6, 0, 0, 0));
    cur.push_back(mk(I_ADDI, 7, 0, 0, 11));
    cur.push_back(mk(I_ADD,  6, 6, 5, 0));
    cur.push_back(mk(I_ADDI, 5, 5, 0, 1));
    cur.push_back(mk(I_BNE,  0, 5, 7, -8));
    cur.push_back(mk(I_SW,   0, 0, 6, 48));
    cur.push_back(mk(I_JAL,  0, 0, 0, 0));
    start_prog("sum");
    run_cycles(50, "sum");
    check("sum_x6",    dut.rf0.reg_file[6], 32'h37);
    check("sum_ram12", dut.dm0.ram[12], 32'h37);
    check("sum_pc",    dut.pc_current_r, 32'h1C);
    run_cycles(3, "sum");
    check("sum_pc_hold", dut.pc_current_r, 32'h1C);
    final_compare("sum");

    // Asynchronous reset mid-program: PC/regs clear at once, RAM kept
    start_prog("midrst");
    run_cycles(12, "midrst");
    begin
      logic [4:0] wr;
      int         sw;
      @(posedge clk);
      model_step(wr, sw);
    end
    #2 rst = 1'b1;
    #1;
    check("midrst_pc", dut.pc_current_r, 32'h0);
    for (int i = 0; i < 32; i++)
      check($sformatf("midrst_x%0d", i), dut.rf0.reg_file[i], 32'h0);
    check("midrst_ram12", dut.dm0.ram[12], m_mem[12]);
    m_pc = 0;
    for (int i = 0; i < 32; i++) m_reg[i] = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_cycles(50, "rerun");
    check("rerun_x6",    dut.rf0.reg_file[6], 32'h37);
    check("rerun_ram12", dut.dm0.ram[12], 32'h37);
    final_compare("rerun");

    // Random programs: seed x1..x7, then random instructions
    for (int p = 0; p < 6; p++) begin
      cur = {};
      for (int r = 1; r < 8; r++) begin
        logic [31:0] v;
        v = $urandom;
        cur.push_back(mk(I_LUI,  r, 0, 0, int'({v[31:12], 12'h000})));
        cur.push_back(mk(I_ADDI, r, r, 0, int'($urandom_range(0, 4095)) - 2048));
      end
      for (int k = 0; k < 46; k++) cur.push_back(rand_ins());
      start_prog($sformatf("rnd%0d", p));
      run_cycles(150, $sformatf("rnd%0d", p));
      final_compare($sformatf("rnd%0d", p));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
